// File: rtl/pc_gen_pkg.sv
// Shared defines for the fetch PC generator: address width, reset vector
// and instruction size defaults, plus the fetch handshake state type.
package pc_gen_pkg;

   localparam int          PC_ADDR_WIDTH   = 32;
   localparam logic [31:0] PC_RESET_VECTOR = 32'h0000_0000;
   localparam int          PC_INST_BYTES   = 4;
   localparam int          PC_BTB_DEPTH    = 16;

   // FS_RESET: fetch not yet started after reset; FS_FETCH: pc_o is a live request.
   typedef enum logic {
      FS_RESET = 1'b0,
      FS_FETCH = 1'b1
   } fetch_state_e;

endpackage

// File: rtl/pc_btb.sv
// Direct-mapped branch target buffer for the fetch PC generator.
// Combinational lookup on the fetch PC, single-port update from exe,
// reset clears every valid bit (tag/target storage is not reset).
// Only instantiated when PC_BTB_EN is defined.
module pc_btb #(
   parameter int ADDR_WIDTH = 32,
   parameter int INST_BYTES = 4,
   parameter int BTB_DEPTH  = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [ADDR_WIDTH-1:0] lk_pc_i,
   output logic                  lk_hit_o,
   output logic [ADDR_WIDTH-1:0] lk_target_o,
   input  logic                  upd_en_i,
   input  logic [ADDR_WIDTH-1:0] upd_pc_i,
   input  logic [ADDR_WIDTH-1:0] upd_target_i,
   input  logic                  upd_taken_i
);

   localparam int OFF   = $clog2(INST_BYTES);
   localparam int IDX   = $clog2(BTB_DEPTH);
   localparam int TAG_W = ADDR_WIDTH - OFF - IDX;

   logic [BTB_DEPTH-1:0]  vld_q;
   logic [TAG_W-1:0]      tag_q [BTB_DEPTH];
   logic [ADDR_WIDTH-1:0] tgt_q [BTB_DEPTH];

   logic [IDX-1:0]   lk_idx, upd_idx;
   logic [TAG_W-1:0] lk_tag, upd_tag;

   assign lk_idx  = lk_pc_i[OFF +: IDX];
   assign lk_tag  = lk_pc_i[ADDR_WIDTH-1 : OFF+IDX];
   assign upd_idx = upd_pc_i[OFF +: IDX];
   assign upd_tag = upd_pc_i[ADDR_WIDTH-1 : OFF+IDX];

   // Byte-offset bits never participate in index or tag.
   generate
      if (OFF > 0) begin : g_lsb
         logic unused_lsb;
         assign unused_lsb = ^{lk_pc_i[OFF-1:0], upd_pc_i[OFF-1:0]};
      end
   endgenerate

   // Lookup reads the registered table, so a same-cycle update is not visible.
   always_comb begin
      lk_hit_o    = vld_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
      lk_target_o = tgt_q[lk_idx];
   end

   // Valid bits: set on taken, cleared on not-taken only when the tag matches.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         vld_q <= '0;
      end else if (upd_en_i) begin
         if (upd_taken_i)
            vld_q[upd_idx] <= 1'b1;
         else if (tag_q[upd_idx] == upd_tag)
            vld_q[upd_idx] <= 1'b0;
      end
   end

   // Tag/target payload is written only by taken updates.
   always_ff @(posedge clk_i) begin
      if (upd_en_i && upd_taken_i) begin
         tag_q[upd_idx] <= upd_tag;
         tgt_q[upd_idx] <= upd_target_i;
      end
   end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: next-PC priority mux (trap > jump > stall > handshake
// > prediction > sequential) and fetch valid/ready handshake state.
// Macro PC_BTB_EN builds the pc_btb predictor; without it pred_taken_o is 0,
// pred_target_o is the sequential PC and the upd_* inputs are ignored.
module pc_gen
   import pc_gen_pkg::*;
#(
   parameter int                    ADDR_WIDTH   = PC_ADDR_WIDTH,
   parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = ADDR_WIDTH'(PC_RESET_VECTOR),
   parameter int                    INST_BYTES   = PC_INST_BYTES,
   parameter int                    BTB_DEPTH    = PC_BTB_DEPTH
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  stall_i,
   input  logic                  jump_en_i,
   input  logic [ADDR_WIDTH-1:0] jump_addr_i,
   input  logic                  trap_en_i,
   input  logic [ADDR_WIDTH-1:0] trap_addr_i,
   input  logic                  ready_i,
   input  logic                  upd_en_i,
   input  logic [ADDR_WIDTH-1:0] upd_pc_i,
   input  logic [ADDR_WIDTH-1:0] upd_target_i,
   input  logic                  upd_taken_i,
   output logic [ADDR_WIDTH-1:0] pc_o,
   output logic                  valid_o,
   output logic                  pred_taken_o,
   output logic [ADDR_WIDTH-1:0] pred_target_o
);

   fetch_state_e          state_q, state_d;
   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic [ADDR_WIDTH-1:0] pc_seq;
   logic                  hit;
   logic [ADDR_WIDTH-1:0] hit_tgt;

   // Wraps modulo 2^ADDR_WIDTH by construction.
   assign pc_seq = pc_q + ADDR_WIDTH'(INST_BYTES);

`ifdef PC_BTB_EN
   pc_btb #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .INST_BYTES (INST_BYTES),
      .BTB_DEPTH  (BTB_DEPTH)
   ) u_btb (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .lk_pc_i      (pc_q),
      .lk_hit_o     (hit),
      .lk_target_o  (hit_tgt),
      .upd_en_i     (upd_en_i),
      .upd_pc_i     (upd_pc_i),
      .upd_target_i (upd_target_i),
      .upd_taken_i  (upd_taken_i)
   );
`else
   logic unused_upd;
   assign unused_upd = ^{upd_en_i, upd_pc_i, upd_target_i, upd_taken_i};
   assign hit        = 1'b0;
   assign hit_tgt    = pc_seq;
`endif

   assign pc_o          = pc_q;
   assign valid_o       = (state_q == FS_FETCH);
   assign pred_taken_o  = hit;
   assign pred_target_o = hit ? hit_tgt : pc_seq;

   // Next-PC selection; redirects override stall and the handshake.
   always_comb begin
      state_d = FS_FETCH;
      pc_d    = pc_q;
      if (trap_en_i)
         pc_d = trap_addr_i;
      else if (jump_en_i)
         pc_d = jump_addr_i;
      else if (stall_i)
         pc_d = pc_q;
      else if (!(valid_o && ready_i))
         pc_d = pc_q;
      else if (hit)
         pc_d = hit_tgt;
      else
         pc_d = pc_seq;
   end

   // PC and handshake state registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= FS_RESET;
         pc_q    <= RESET_VECTOR;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: the stimulus process steps a behavioural
// model and queues the expected outputs; a negedge monitor pops and compares.
module tb_pc_gen;

   localparam int          AW    = 32;
   localparam int          IB    = 4;
   localparam int          DEPTH = 16;
   localparam logic [31:0] RV    = 32'h0;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          stall = 0, jump_en = 0, trap_en = 0, ready = 0;
   logic [AW-1:0] jump_addr = '0, trap_addr = '0;
   logic          upd_en = 0, upd_taken = 0;
   logic [AW-1:0] upd_pc = '0, upd_target = '0;
   logic [AW-1:0] pc_o, pred_target_o;
   logic          valid_o, pred_taken_o;

   pc_gen #(.ADDR_WIDTH(AW), .RESET_VECTOR(RV), .INST_BYTES(IB), .BTB_DEPTH(DEPTH)) dut (
      .clk_i(clk), .rst_i(rst), .stall_i(stall),
      .jump_en_i(jump_en), .jump_addr_i(jump_addr),
      .trap_en_i(trap_en), .trap_addr_i(trap_addr),
      .ready_i(ready),
      .upd_en_i(upd_en), .upd_pc_i(upd_pc), .upd_target_i(upd_target), .upd_taken_i(upd_taken),
      .pc_o(pc_o), .valid_o(valid_o), .pred_taken_o(pred_taken_o), .pred_target_o(pred_target_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic        v;
      logic        pt;
      logic [31:0] ptg;
   } exp_t;

   typedef struct {
      bit          v;
      logic [31:0] pc;
      logic [31:0] tgt;
   } ent_t;

   exp_t  q[$];
   string nq[$];
   int    nchk = 0;
   int    nerr = 0;

   // Reference model: architectural PC, fetch-started flag, and a table of
   // trained branches remembered by their full PC.
   logic [31:0] m_pc;
   bit          m_v;
   ent_t        mb[DEPTH];

   function automatic int slot(logic [31:0] pc);
      return int'((pc / IB) % DEPTH);
   endfunction

   function automatic bit same_line_group(logic [31:0] a, logic [31:0] b);
      return (a / (IB * DEPTH)) == (b / (IB * DEPTH));
   endfunction

   function automatic bit m_hit(logic [31:0] pc);
`ifdef PC_BTB_EN
      return mb[slot(pc)].v && same_line_group(mb[slot(pc)].pc, pc);
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [31:0] m_tgt(logic [31:0] pc);
      return m_hit(pc) ? mb[slot(pc)].tgt : pc + IB;
   endfunction

   function automatic exp_t mk_exp();
      exp_t e;
      e.pc  = m_pc;
      e.v   = m_v;
      e.pt  = m_hit(m_pc);
      e.ptg = m_tgt(m_pc);
      return e;
   endfunction

   task automatic model_reset();
      m_pc = RV;
      m_v  = 0;
      for (int i = 0; i < DEPTH; i++) mb[i].v = 0;
   endtask

   task automatic check(input string nm, input exp_t e);
      nchk++;
      if (pc_o !== e.pc || valid_o !== e.v || pred_taken_o !== e.pt || pred_target_o !== e.ptg) begin
         nerr++;
         $display("FAIL %s: got pc=%h v=%b pt=%b ptg=%h, want pc=%h v=%b pt=%b ptg=%h",
                  nm, pc_o, valid_o, pred_taken_o, pred_target_o, e.pc, e.v, e.pt, e.ptg);
      end
   endtask

   // Monitor: one expected record per cycle, compared mid-cycle.
   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t  e;
         string nm;
         e  = q.pop_front();
         nm = nq.pop_front();
         check(nm, e);
      end
   end

   // Drive one cycle of inputs and queue what the outputs must be after the edge.
   task automatic drive(input bit r, input bit tr, input logic [31:0] ta,
                        input bit jp, input logic [31:0] ja, input bit st, input bit rd,
                        input bit ue, input logic [31:0] up, input logic [31:0] ut,
                        input bit uk, input string nm);
      logic [31:0] nxt;
      @(negedge clk);
      #1;
      rst = r; trap_en = tr; trap_addr = ta; jump_en = jp; jump_addr = ja;
      stall = st; ready = rd; upd_en = ue; upd_pc = up; upd_target = ut; upd_taken = uk;
      if (r) begin
         model_reset();
      end else begin
         nxt = m_pc;
         if (tr)                     nxt = ta;
         else if (jp)                nxt = ja;
         else if (st)                nxt = m_pc;
         else if (!(m_v && rd))      nxt = m_pc;
         else                        nxt = m_tgt(m_pc);
`ifdef PC_BTB_EN
         if (ue) begin
            if (uk) begin
               mb[slot(up)].v   = 1;
               mb[slot(up)].pc  = up;
               mb[slot(up)].tgt = ut;
            end else if (same_line_group(mb[slot(up)].pc, up)) begin
               mb[slot(up)].v = 0;
            end
         end
`endif
         m_pc = nxt;
         m_v  = 1;
      end
      q.push_back(mk_exp());
      nq.push_back(nm);
   endtask

   task automatic idle(input bit rd, input string nm);
      drive(0, 0, 0, 0, 0, 0, rd, 0, 0, 0, 0, nm);
   endtask

   task automatic jump(input logic [31:0] a, input string nm);
      drive(0, 0, 0, 1, a, 0, 1, 0, 0, 0, 0, nm);
   endtask

   task automatic jump_upd(input logic [31:0] a, input logic [31:0] up,
                           input logic [31:0] ut, input bit uk, input string nm);
      drive(0, 0, 0, 1, a, 0, 1, 1, up, ut, uk, nm);
   endtask

   // Reset asserted between edges; outputs must change before the next edge.
   task automatic async_reset(input string nm);
      @(negedge clk);
      #3;
      rst = 1;
      #1;
      model_reset();
      check({nm, "_async"}, mk_exp());
      q.push_back(mk_exp());
      nq.push_back(nm);
   endtask

   function automatic logic [31:0] rnd_addr();
      return ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2);
   endfunction

   initial begin
      model_reset();
      // Reset hold and release, free-running fetch.
      drive(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, "rst_hold");
      drive(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, "rst_hold");
      idle(1, "rel_first");
      idle(1, "seq_4");
      idle(1, "seq_8");
      // Backpressure holds pc.
      repeat (3) idle(0, "hold_nrdy");
      idle(1, "seq_c");
      // Redirect priority over stall.
      drive(0, 1, 32'h80, 1, 32'h100, 1, 0, 0, 0, 0, 0, "trap_prio");
      drive(0, 0, 0, 1, 32'h100, 1, 0, 0, 0, 0, 0, "jump_stall");
      drive(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, "stall_hold");
      // Train 0x10 -> 0x200 in the same cycle as a jump to it.
      jump_upd(32'h10, 32'h10, 32'h200, 1, "train_10");
      idle(1, "pred_200");
      // Same-cycle not-taken update on the looked-up slot sees old contents.
      jump_upd(32'h10, 32'h10, 32'h200, 1, "retrain_10");
      drive(0, 0, 0, 0, 0, 0, 1, 1, 32'h10, 0, 0, "upd_vs_lookup");
      jump(32'h10, "revisit_10");
      idle(1, "seq_14");
      // Aliasing at 0x50.
      jump_upd(32'h50, 32'h10, 32'h200, 1, "alias_50");
      jump_upd(32'h10, 32'h50, 32'h0, 0, "nt_alias");
      idle(1, "kept_200");
      // Wrap-around.
      jump(32'hFFFF_FFFC, "top");
      idle(1, "wrap_0");
      // Async reset at 0x44 clears prediction.
      jump_upd(32'h44, 32'h10, 32'h300, 1, "to_44");
      async_reset("rst_mid");
      drive(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, "rst_hold2");
      idle(1, "rel2");
      jump(32'h10, "cold_10");
      idle(1, "cold_14");
      // Randomized traffic.
      for (int i = 0; i < 500; i++) begin
         drive(($urandom % 150) == 0, ($urandom % 16) == 0, rnd_addr(),
               ($urandom % 8) == 0, rnd_addr(), ($urandom % 5) == 0, ($urandom % 4) != 0,
               ($urandom % 3) == 0, rnd_addr(), rnd_addr(), ($urandom % 3) != 0, "rand");
      end
      idle(1, "tail");
      repeat (2) @(negedge clk);
      #2;
      nchk++;
      if (q.size() != 0) begin
         nerr++;
         $display("FAIL drain: got %0d pending, want 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
- REQ-001 Parameter ADDR_WIDTH, default 32: width of all address ports.
- REQ-002 Parameter RESET_VECTOR, default 32'h0000_0000: first fetch address after reset.
- REQ-003 Parameter INST_BYTES, default 4: sequential PC increment in bytes.
- REQ-004 Parameter BTB_DEPTH, default 16, power of two >= 2: branch target buffer entries.
- REQ-005 clk_i  input  1: single clock; all state updates on the rising edge.
- REQ-006 rst_i  input  1: asynchronous, active-high reset.
- REQ-007 stall_i  input  1: hazard unit hold request.
- REQ-008 jump_en_i, jump_addr_i  input  1, ADDR_WIDTH: exe-stage redirect, including mispredict recovery.
- REQ-009 trap_en_i, trap_addr_i  input  1, ADDR_WIDTH: trap/interrupt redirect.
- REQ-010 ready_i  input  1: fetch memory accepts the current address.
- REQ-011 upd_en_i, upd_pc_i, upd_target_i, upd_taken_i  input  1, ADDR_WIDTH, ADDR_WIDTH, 1: resolved branch from exe.
- REQ-012 pc_o  output  ADDR_WIDTH: current fetch address.
- REQ-013 valid_o  output  1: pc_o is a valid fetch request.
- REQ-014 pred_taken_o, pred_target_o  output  1, ADDR_WIDTH: BTB prediction for pc_o, carried down the pipe.

Function
- REQ-015 Fetch handshake: pc_o is accepted in a cycle where valid_o=1 and ready_i=1; pc_o and valid_o stay stable while valid_o=1 and ready_i=0, except on redirect.
- REQ-016 Next-PC priority, highest first: trap_en_i -> trap_addr_i; jump_en_i -> jump_addr_i; stall_i -> hold; no handshake -> hold; pred_taken_o -> pred_target_o; else pc_o + INST_BYTES.
- REQ-017 Redirects (trap/jump) take effect on the next edge regardless of stall_i, ready_i or valid_o, and discard any unaccepted pc_o.
- REQ-018 Addition wraps modulo 2^ADDR_WIDTH; no overflow flag.
- REQ-019 BTB is direct-mapped; index = pc[log2(INST_BYTES)+IDX-1 : log2(INST_BYTES)], IDX = log2(BTB_DEPTH); tag = all bits above the index; entry = {valid, tag, target}.
- REQ-020 Lookup is combinational on pc_o: pred_taken_o=1 if entry valid and tag matches, with pred_target_o = entry target; otherwise pred_taken_o=0 and pred_target_o = pc_o + INST_BYTES.
- REQ-021 Update on upd_en_i at the edge: taken=1 writes {1, tag, upd_target_i}; taken=0 clears valid only on tag match, otherwise no change.
- REQ-022 An update and a lookup on the same index in the same cycle: the lookup returns the pre-update contents.
- REQ-023 A trap or jump in the same cycle as upd_en_i performs both the redirect and the table write.

Reset
- REQ-024 Asserting rst_i immediately sets pc_o=RESET_VECTOR, valid_o=0, and clears all BTB valid bits, including mid-handshake.
- REQ-025 On the first rising edge after rst_i deasserts, valid_o becomes 1 and pc_o stays RESET_VECTOR; redirects on that edge are still honoured per REQ-016.
- REQ-026 While valid_o=0, pc_o does not advance sequentially.

Configuration
- REQ-027 Macro PC_BTB_EN: when defined, the BTB and prediction are built as specified.
- REQ-028 When PC_BTB_EN is undefined, no BTB storage exists; pred_taken_o is tied to 0, pred_target_o = pc_o + INST_BYTES, and the upd_* inputs are ignored.

Structure
- REQ-029 ADDR_WIDTH, RESET_VECTOR default and INST_BYTES default live in the shared defines file; BTB entry field widths are derived locally from parameters.
- REQ-030 The BTB is a sub-module pc_btb (lookup port, update port, reset clear); pc_gen holds next-PC muxing and handshake state.

Verification
- REQ-031 Reset release, ready_i=1, no events -> pc_o 0x0, 0x0, 0x4, 0x8 on successive edges; valid_o 0 then 1.
- REQ-032 pc_o=0x8, ready_i=0 for 3 cycles -> pc_o holds 0x8; then ready_i=1 -> 0xC.
- REQ-033 stall_i=1, jump_en_i=1 to 0x100, trap_en_i=1 to 0x80 in the same cycle -> pc_o=0x80 next edge; jump alone -> 0x100.
- REQ-034 Update pc 0x10 taken to 0x200, then fetch reaches 0x10 -> pred_taken_o=1, next pc_o=0x200; update not-taken for 0x10 -> next visit goes to 0x14.
- REQ-035 Aliasing: entry trained at 0x10; lookup of 0x50 (same index at depth 16, different tag) -> pred_taken_o=0; not-taken update for 0x50 leaves the 0x10 entry intact.
- REQ-036 Assert rst_i asynchronously mid-run at pc_o=0x44 -> pc_o=0x0 and valid_o=0 before the next edge; the previously trained entry no longer predicts.
